// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO for the pipelined MIPS core.
// Results are computed at issue, held pending, and committed after N busy cycles.
module md_unit #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [3:0]  mdOp,
   input  logic [31:0] srcA,
   input  logic [31:0] srcB,
   input  logic        use_md,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        md_stall
);

   localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;

   typedef enum logic {IDLE, RUN} state_t;

   state_t             state;
   logic [CNT_W-1:0]   counter;
   logic [31:0]        pendHi;
   logic [31:0]        pendLo;
   logic               pendWr;

   logic signed [63:0] sProd;
   logic [63:0]        uProd;
   logic [31:0]        divisor;
   logic [31:0]        absA;
   logic [31:0]        absB;
   logic [31:0]        magQ;
   logic [31:0]        magR;
   logic [31:0]        sQuot;
   logic [31:0]        sRem;
   logic [31:0]        uQuot;
   logic [31:0]        uRem;
   logic               isArith;

   assign sProd = $signed({{32{srcA[31]}}, srcA}) * $signed({{32{srcB[31]}}, srcB});
   assign uProd = {32'd0, srcA} * {32'd0, srcB};

   // Divisor forced nonzero so the datapath stays defined; a zero-divide never commits.
   assign divisor = (srcB == 32'd0) ? 32'd1 : srcB;
   assign absA    = srcA[31] ? (~srcA + 32'd1) : srcA;
   assign absB    = divisor[31] ? (~divisor + 32'd1) : divisor;
   assign magQ    = absA / absB;
   assign magR    = absA % absB;
   assign sQuot   = (srcA[31] ^ divisor[31]) ? (~magQ + 32'd1) : magQ;
   assign sRem    = srcA[31] ? (~magR + 32'd1) : magR;
   assign uQuot   = srcA / divisor;
   assign uRem    = srcA % divisor;

   assign isArith  = (mdOp == OP_MULT) || (mdOp == OP_MULTU) || (mdOp == OP_DIV) || (mdOp == OP_DIVU);
   assign busy     = (state == RUN);
   assign md_stall = use_md & (busy | (start & isArith));

   // Issue/commit sequencer; starts while busy are ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         counter <= '0;
         hi      <= '0;
         lo      <= '0;
         pendHi  <= '0;
         pendLo  <= '0;
         pendWr  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  case (mdOp)
                     OP_MULT: begin
                        pendHi  <= sProd[63:32];
                        pendLo  <= sProd[31:0];
                        pendWr  <= 1'b1;
                        counter <= CNT_W'(MULT_CYCLES - 1);
                        state   <= RUN;
                     end
                     OP_MULTU: begin
                        pendHi  <= uProd[63:32];
                        pendLo  <= uProd[31:0];
                        pendWr  <= 1'b1;
                        counter <= CNT_W'(MULT_CYCLES - 1);
                        state   <= RUN;
                     end
                     OP_DIV: begin
                        pendHi  <= sRem;
                        pendLo  <= sQuot;
                        pendWr  <= (srcB != 32'd0);
                        counter <= CNT_W'(DIV_CYCLES - 1);
                        state   <= RUN;
                     end
                     OP_DIVU: begin
                        pendHi  <= uRem;
                        pendLo  <= uQuot;
                        pendWr  <= (srcB != 32'd0);
                        counter <= CNT_W'(DIV_CYCLES - 1);
                        state   <= RUN;
                     end
                     OP_MTHI: hi <= srcA;
                     OP_MTLO: lo <= srcA;
                     default: ;
                  endcase
               end
            end
            RUN: begin
               if (counter == '0) begin
                  if (pendWr) begin
                     hi <= pendHi;
                     lo <= pendLo;
                  end
                  state <= IDLE;
               end else begin
                  counter <= counter - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: scoreboard of expected {hi,lo} pushed at issue, popped at commit.
module tb_md_unit;

   localparam int unsigned MULT_N = 5;
   localparam int unsigned DIV_N  = 10;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [3:0]  mdOp;
   logic [31:0] srcA;
   logic [31:0] srcB;
   logic        use_md;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        md_stall;

   int errors = 0;
   int checks = 0;

   logic [63:0] expQ[$];
   logic [31:0] modelHi = 32'd0;
   logic [31:0] modelLo = 32'd0;

   md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mdOp(mdOp), .srcA(srcA), .srcB(srcB),
      .use_md(use_md), .busy(busy), .hi(hi), .lo(lo), .md_stall(md_stall)
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] cHi, input logic [31:0] cLo);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         4'd1: begin p = 64'(sa * sb); return p; end
         4'd2: return {32'd0, a} * {32'd0, b};
         4'd3: begin
            if (b == 32'd0) return {cHi, cLo};
            q = sa / sb;
            r = sa % sb;
            return {32'(r), 32'(q)};
         end
         4'd4: begin
            if (b == 32'd0) return {cHi, cLo};
            return {a % b, a / b};
         end
         4'd5: return {a, cLo};
         4'd6: return {cHi, a};
         default: return {cHi, cLo};
      endcase
   endfunction

   function automatic int cyclesFor(input logic [3:0] op);
      if (op == 4'd1 || op == 4'd2) return MULT_N;
      if (op == 4'd3 || op == 4'd4) return DIV_N;
      return 0;
   endfunction

   // Issue one op, watch the busy window, then pop and compare the committed HI/LO.
   task automatic runOp(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit useMd, input bit inject);
      logic [63:0] exp;
      int cnt;
      bit arith;
      arith = (cyclesFor(op) != 0);
      expQ.push_back(model(op, a, b, modelHi, modelLo));
      @(negedge clk);
      start = 1'b1; mdOp = op; srcA = a; srcB = b; use_md = useMd;
      #1 checkVal({tag, "_stall_issue"}, 64'(md_stall), 64'(useMd && arith));
      @(posedge clk);
      #1 start = 1'b0; mdOp = 4'd0;
      cnt = 0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (!busy) break;
         cnt++;
         checkVal({tag, "_hold"}, {hi, lo}, {modelHi, modelLo});
         if (useMd) checkVal({tag, "_stall_busy"}, 64'(md_stall), 64'd1);
         if (inject && cnt == 2) begin
            start = 1'b1; mdOp = 4'd5; srcA = 32'hDEADBEEF;
         end
      end
      checkVal({tag, "_cycles"}, 64'(cnt), 64'(cyclesFor(op)));
      exp = expQ.pop_front();
      checkVal({tag, "_hilo"}, {hi, lo}, exp);
      checkVal({tag, "_busy_after"}, 64'(busy), 64'd0);
      if (useMd) checkVal({tag, "_stall_after"}, 64'(md_stall), 64'd0);
      modelHi = exp[63:32];
      modelLo = exp[31:0];
      use_md = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; mdOp = 4'd0; srcA = '0; srcB = '0; use_md = 1'b0;
      #12;
      checkVal("reset_state", {63'(busy), hi, lo, md_stall}, 64'd0);
      @(negedge clk) rst_n = 1'b1;

      runOp("mult",  4'd1, 32'hFFFFFFFE, 32'd3, 1'b1, 1'b0);
      checkVal("mult_ref", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);
      runOp("multu", 4'd2, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0);
      checkVal("multu_ref", {hi, lo}, 64'h00000002_FFFFFFFA);
      runOp("div",   4'd3, 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0);
      checkVal("div_ref", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
      runOp("divu",  4'd4, 32'd7, 32'd2, 1'b0, 1'b0);
      checkVal("divu_ref", {hi, lo}, 64'h00000001_00000003);
      runOp("divovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
      checkVal("divovf_ref", {hi, lo}, 64'h00000000_80000000);
      runOp("mthi11", 4'd5, 32'h11, 32'd0, 1'b0, 1'b0);
      runOp("mtlo22", 4'd6, 32'h22, 32'd0, 1'b0, 1'b0);
      runOp("div0",  4'd3, 32'd100, 32'd0, 1'b1, 1'b0);
      checkVal("div0_ref", {hi, lo}, 64'h00000011_00000022);
      runOp("divu0", 4'd4, 32'd100, 32'd0, 1'b0, 1'b0);
      runOp("ignore", 4'd1, 32'd1234, 32'd5678, 1'b1, 1'b1);
      checkVal("ignore_ref", {hi, lo}, 64'(64'd1234 * 64'd5678));
      runOp("mthi", 4'd5, 32'hDEADBEEF, 32'd0, 1'b1, 1'b0);
      checkVal("mthi_ref", 64'(hi), 64'hDEADBEEF);
      runOp("mtlo", 4'd6, 32'h1234, 32'd0, 1'b0, 1'b0);
      checkVal("mtlo_ref", 64'(lo), 64'h1234);
      runOp("nop7", 4'd7, 32'hCAFEF00D, 32'd9, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         runOp("rnd_mult", 4'd1, $urandom, $urandom, 1'b0, 1'b0);
         runOp("rnd_div",  4'd3, $urandom, $urandom_range(1, 32'hFFFF), 1'b0, 1'b0);
         runOp("rnd_divu", 4'd4, $urandom, $urandom, 1'b0, 1'b0);
      end

      // Asynchronous reset mid-run: immediate clear, and the aborted result never lands.
      @(negedge clk);
      start = 1'b1; mdOp = 4'd1; srcA = 32'd3; srcB = 32'd4;
      @(posedge clk);
      #1 start = 1'b0; mdOp = 4'd0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 checkVal("rst_async", {62'(busy), hi}, 64'd0);
      checkVal("rst_async_lo", 64'(lo), 64'd0);
      #3 rst_n = 1'b1;
      repeat (12) @(negedge clk);
      checkVal("rst_no_commit", {hi, lo}, 64'd0);
      checkVal("rst_idle", 64'(busy), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit for the pipelined MIPS core. It sits beside the ALU in the E stage and owns the HI/LO registers.
- Sequences each mult/div operation with a cycle counter and a busy flag.
- Raises a stall request to the D-stage hazard logic while a dependent mult/div instruction (mfhi/mflo/mthi/mtlo/mult/div...) must wait.
- Driven by mdOp/start decoded by the controller.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  E-stage instr is mult/multu/div/divu/mthi/mtlo; single-cycle qualifier
mdOp  input  4  1=MULT 2=MULTU 3=DIV 4=DIVU 5=MTHI 6=MTLO; other values = no-op
srcA  input  32  rs operand (forwarded)
srcB  input  32  rt operand (forwarded)
use_md  input  1  D-stage instr reads/writes HI/LO or starts an md op
busy  output  1  operation in progress
hi  output  32  HI register
lo  output  32  LO register
md_stall  output  1  stall request to hazard unit

Behaviour:
- Reset: while rst_n=0, regardless of clk: busy=0, counter=0, hi=0, lo=0, pending result=0. A reset mid-operation aborts the operation, and no result is committed.
- States:
  - IDLE (busy=0): at a clk edge with start=1, behaviour depends on mdOp.
    - MULT/MULTU/DIV/DIVU: compute the 64-bit result from srcA/srcB, hold it in pending HI/LO, load counter with N-1 (N = MULT_CYCLES or DIV_CYCLES), go to RUN.
    - MTHI: hi<=srcA, stay in IDLE.
    - MTLO: lo<=srcA, stay in IDLE.
    - Any other mdOp: no effect.
  - RUN (busy=1): counter decrements each edge. At the edge where counter==0, commit the pending result to hi/lo, set busy=0 and return to IDLE.
- Timing: start sampled at edge k gives busy=1 from after edge k through after edge k+N-1, and busy=0 with new hi/lo visible after edge k+N. Exactly N cycles of busy.
- start while busy=1 is a protocol violation, prevented by md_stall. The unit ignores it: no restart and no HI/LO write.
- hi/lo hold their old values throughout RUN. mfhi/mflo read them combinationally but are stalled via md_stall until commit.
- md_stall = use_md & (busy | (start & mdOp in {1,2,3,4})). This is combinational.
- Arithmetic:
  - MULT: signed 32x32->64, {hi,lo}=product.
  - MULTU: unsigned 32x32->64, {hi,lo}=product.
  - DIV: signed. lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - DIVU: unsigned quotient/remainder.
- Divide by zero (srcB=0, DIV/DIVU): busy still runs the full DIV_CYCLES, but hi/lo are left unchanged at commit.
- Back-to-back operations: a new start is accepted at the edge after busy falls, which is the first IDLE cycle.

Test Plan:
- Reset: rst_n=0 asserted mid-RUN, asynchronously -> busy, hi and lo go to 0 immediately; after release the old result never appears.
- MULT: srcA=0xFFFFFFFE (-2), srcB=3, start one cycle -> busy=1 for exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV: srcA=-7 (0xFFFFFFF9), srcB=2 -> busy 10 cycles, lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU with srcA=7, srcB=2 -> lo=3, hi=1.
- Boundary divides:
  - 0x80000000 / 0xFFFFFFFF (DIV) -> lo=0x80000000, hi=0.
  - DIV with srcB=0 after hi=0x11, lo=0x22 -> busy 10 cycles, then hi=0x11, lo=0x22 unchanged.
- Stall and ignore:
  - use_md=1 during RUN -> md_stall=1 every busy cycle and 0 after commit.
  - use_md=1 with start=1, mdOp=MULT in IDLE -> md_stall=1 in that same cycle.
  - start=1, mdOp=MTHI while busy -> ignored; hi equals the committed product.
- MTHI/MTLO: srcA=0xDEADBEEF, mdOp=MTHI -> hi=0xDEADBEEF after one edge, busy stays 0. MTLO srcA=0x1234 -> lo=0x1234. mdOp=7 -> no change.
